// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the memory port arbiter: the arbitration state
//   encoding and the encodings driven on the owner output.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CORE  = 2'd1,
        LOAD  = 2'd2,
        YIELD = 2'd3
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CORE = 2'b01;
    localparam logic [1:0] OWN_LD   = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous active-low clear.
//   Ports:
//     clk    - system clock
//     clr_b  - synchronous clear, active low (wins over inc)
//     inc    - count up by one, holding at MAX
//     count  - current count
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             clr_b,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!clr_b) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q >= MAX_V) ? MAX_V : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified memory between the multicycle core and
//   the external program loader/debug port. The loader normally wins; after
//   MAX_BURST consecutive loader grants with the core waiting, the core is
//   given the next cycle.
//   Ports:
//     clk, rst                      - clock, synchronous active-low reset
//     core_req/addr/we/wd           - core access request and payload
//     core_stall                    - core lost arbitration this cycle
//     ld_req/addr/we/wd             - loader access request and payload
//     ld_gnt                        - loader access performed this cycle
//     ld_rvalid                     - previous loader read data is on RD
//     mem_addr/we/wd                - to memory macro
//     owner                         - 00 none, 01 core, 10 loader
//
//   state | meaning
//   IDLE  | no access last cycle, burst count clear
//   CORE  | core owned memory last cycle, burst count clear
//   LOAD  | loader owned memory last cycle, counting consecutive grants
//   YIELD | loader burst cap hit with core waiting; core has priority
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic                  core_we,
    input  logic [DATA_WIDTH-1:0] core_wd,
    output logic                  core_stall,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic                  ld_we,
    input  logic [DATA_WIDTH-1:0] ld_wd,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [1:0]            owner
);

    arb_state_e st_q, st_d;
    logic       ld_rvalid_q, ld_rvalid_d;

    logic       core_win;
    logic       ld_win;
    logic       yield_drop;
    logic       burst_hit;
    logic       cnt_clr_b;
    logic [7:0] burst_cnt;

    // The post-increment count equals MAX_BURST exactly when the current
    // count is at least MAX_BURST-1 (the counter saturates at MAX_BURST).
    assign burst_hit  = burst_cnt >= 8'(MAX_BURST - 1);
    assign yield_drop = (st_q == YIELD) && !core_req;

    // Burst count survives only consecutive loader grants; anything else,
    // including the core giving up its YIELD slot, restarts it.
    assign cnt_clr_b = rst && ld_win && !yield_drop;

    sat_counter #(
        .WIDTH (8),
        .MAX   (MAX_BURST)
    ) u_burst_cnt (
        .clk   (clk),
        .clr_b (cnt_clr_b),
        .inc   (ld_win),
        .count (burst_cnt)
    );

    always_comb begin
        core_win = 1'b0;
        ld_win   = 1'b0;
        if (rst) begin
            if (st_q == YIELD) begin
                if (core_req)    core_win = 1'b1;
                else if (ld_req) ld_win   = 1'b1;
            end else begin
                if (ld_req)        ld_win   = 1'b1;
                else if (core_req) core_win = 1'b1;
            end
        end

        mem_addr = '0;
        mem_we   = 1'b0;
        mem_wd   = '0;
        owner    = OWN_NONE;
        if (ld_win) begin
            mem_addr = ld_addr;
            mem_we   = ld_we;
            mem_wd   = ld_wd;
            owner    = OWN_LD;
        end else if (core_win) begin
            mem_addr = core_addr;
            mem_we   = core_we;
            mem_wd   = core_wd;
            owner    = OWN_CORE;
        end

        core_stall  = core_req && !core_win;
        ld_gnt      = ld_win;
        ld_rvalid_d = ld_win && !ld_we;

        if (yield_drop) begin
            st_d = IDLE;
        end else if (ld_win) begin
            st_d = (burst_hit && core_req) ? YIELD : LOAD;
        end else if (core_win) begin
            st_d = CORE;
        end else begin
            st_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q        <= IDLE;
            ld_rvalid_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            ld_rvalid_q <= ld_rvalid_d;
        end
    end

    assign ld_rvalid = ld_rvalid_q;

endmodule
